// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with single-outstanding valid/ready bus
module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [1:0]        lsb_q, lsb_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;

    logic              is_load;
    logic              is_mem;
    logic              access;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;

    // RegWriteM is carried on the port for hazard visibility only.
    logic              unused_regwrite;
    assign unused_regwrite = RegWriteM;

    assign is_load = (ResultSrcM == 2'b01);
    assign is_mem  = MemWriteM | is_load;

    // Alignment and size legality of the current M-stage memory instruction
    always_comb begin
        misalign_err = 1'b0;
        if (is_mem) begin
            case (MemSizeM)
                2'd0:    misalign_err = 1'b0;
                2'd1:    misalign_err = ALUResultM[0];
                2'd2:    misalign_err = (ALUResultM[1:0] != 2'b00);
                default: misalign_err = 1'b1;
            endcase
        end
    end

    assign access = is_mem & ~misalign_err;

    // Byte-lane enables and lane-replicated store data for the request beat
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
        case (MemSizeM)
            2'd0: begin
                be_c    = 4'b0001 << ALUResultM[1:0];
                wdata_c = {4{WriteDataM[7:0]}};
            end
            2'd1: begin
                be_c    = 4'b0011 << ALUResultM[1:0];
                wdata_c = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = WriteDataM;
            end
        endcase
    end

    // Load lane extraction from the address and size latched when the request launched
    always_comb begin
        shifted  = mem_rdata >> {lsb_q, 3'b000};
        load_ext = mem_rdata;
        case (size_q)
            2'd0:    load_ext = zext_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = zext_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state and registered-output computation for the IDLE/REQ/DONE sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        lsb_d       = lsb_q;
        size_d      = size_q;
        zext_d      = zext_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d     = S_REQ;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
                    mem_be_d    = be_c;
                    mem_wdata_d = wdata_c;
                    lsb_d       = ALUResultM[1:0];
                    size_d      = MemSizeM;
                    zext_d      = MemSignM;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = load_ext;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            bus_err_q   <= 1'b0;
            lsb_q       <= 2'd0;
            size_q      <= 2'd0;
            zext_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            lsb_q       <= lsb_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
        end
    end

    // Stall while launching a request and while it is outstanding; never during reset
    always_comb begin
        StallM = 1'b0;
        if (!RST) begin
            StallM = ((state_q == S_IDLE) && access) || (state_q == S_REQ);
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign ReadDataM = rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with random accesses
module tb_mem_stage_lsu;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [1:0]  MemSizeM = 2'd0;
    logic        MemSignM = 1'b0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    mem_stage_lsu #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .MemSizeM(MemSizeM), .MemSignM(MemSignM), .ReadDataM(ReadDataM),
        .StallM(StallM), .misalign_err(misalign_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
        int          stall;
        int          reqc;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int wait_left = 0;
    logic [31:0] rd_val = 32'd0;
    logic [31:0] exp_rd = 32'd0;
    int exp_berr_pulses = 0;
    int berr_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference rules written from the load/store definitions
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                               input logic [1:0] size, input bit zext);
        longint v;
        int nbits;
        if (size == 2) return rd;
        nbits = 8 * (1 << size);
        v = longint'(rd >> (8 * (addr % 4)));
        v = v % (64'd1 << nbits);
        if (!zext && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
        int nbytes = 1 << size;
        logic [3:0] be = 4'd0;
        for (int i = 0; i < nbytes; i++) be[(addr % 4) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] size);
        int nbytes = 1 << size;
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        return r;
    endfunction

    // Bus slave: ready after the requested number of wait cycles, junk data otherwise
    always @(posedge CLK) begin
        #1;
        if (mem_req) begin
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rd_val;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            mem_ready = 1'($urandom % 2);
            mem_rdata = $urandom;
        end
    end

    // Monitor: checks each request beat and each completion against the scoreboard
    int prev_req = 0;
    int stall_run = 0;
    int last_run = 0;
    int req_run = 0;
    bus_exp_t held;
    always @(negedge CLK) begin
        bus_exp_t be_e;
        resp_exp_t re;
        if (mem_req && prev_req == 0) begin
            if (bus_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                be_e = bus_q.pop_front();
                check("mem_addr", mem_addr, be_e.addr);
                check("mem_be", {28'd0, mem_be}, {28'd0, be_e.be});
                check("mem_we", {31'd0, mem_we}, {31'd0, be_e.we});
                if (be_e.we) check("mem_wdata", mem_wdata, be_e.wdata);
            end
            held = '{mem_addr, mem_be, mem_we, mem_wdata};
        end else if (mem_req && prev_req != 0) begin
            check("hold_addr", mem_addr, held.addr);
            check("hold_be_we_wdata", {27'd0, mem_be, mem_we} ^ mem_wdata,
                  {27'd0, held.be, held.we} ^ held.wdata);
        end
        if (mem_req) req_run++;
        if (StallM) stall_run++;
        else if (stall_run != 0) begin
            last_run = stall_run;
            stall_run = 0;
        end
        if (!mem_req && prev_req != 0) begin
            if (resp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                re = resp_q.pop_front();
                check("ReadDataM", ReadDataM, re.rd);
                check("bus_err_done", {31'd0, bus_err}, {31'd0, re.berr});
                check("stall_done", {31'd0, StallM}, 32'd0);
                check("stall_cycles", last_run, re.stall);
                check("req_cycles", req_run, re.reqc);
            end
            req_run = 0;
        end
        if (bus_err) berr_pulses++;
        prev_req = mem_req ? 1 : 0;
    end

    task automatic clear_inputs();
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0;
        ALUResultM = $urandom; WriteDataM = $urandom; MemSizeM = 2'($urandom); MemSignM = 1'($urandom);
    endtask

    task automatic drive(input bit st, input bit ld, input logic [1:0] size, input bit zext,
                         input logic [31:0] addr, input logic [31:0] wd);
        RegWriteM  = ld;
        ResultSrcM = ld ? 2'b01 : (($urandom % 2) ? 2'b10 : 2'b00);
        MemWriteM  = st;
        MemSizeM   = size;
        MemSignM   = zext;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    // waits < 0 means the bus never answers
    task automatic run_access(input bit st, input bit ld, input logic [1:0] size, input bit zext,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits);
        bit bad;
        bit done;
        bad = (st || ld) && (size == 3 || (addr % (1 << size)) != 0);
        @(posedge CLK); #1;
        if (!(st || ld) || bad) begin
            drive(st, ld, size, zext, addr, wd);
            @(negedge CLK);
            check(bad ? "misalign_err_set" : "misalign_err_nop", {31'd0, misalign_err}, {31'd0, bad});
            check("stall_no_access", {31'd0, StallM}, 32'd0);
            check("readdata_hold", ReadDataM, exp_rd);
            @(posedge CLK); #1;
            clear_inputs();
            @(negedge CLK);
            check("no_req_issued", {31'd0, mem_req}, 32'd0);
            return;
        end
        bus_q.push_back('{addr & 32'hFFFF_FFFC, model_be(addr, size), st, model_wdata(wd, size)});
        if (waits < 0) begin
            exp_rd = st ? exp_rd : 32'd0;
            if (!st) begin end
            exp_rd = 32'd0;
            resp_q.push_back('{32'd0, 1'b1, TIMEOUT + 1, TIMEOUT});
            exp_berr_pulses++;
            wait_left = 1000000;
        end else begin
            if (!st) exp_rd = model_load(rd, addr, size, zext);
            resp_q.push_back('{exp_rd, 1'b0, waits + 2, waits + 1});
            wait_left = waits;
        end
        rd_val = rd;
        drive(st, ld, size, zext, addr, wd);
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!StallM) begin
                done = 1;
                break;
            end
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a load flagged: stall must stay low and all state cleared
        drive(0, 1, 2'd2, 0, 32'h100, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we_be_err", {26'd0, mem_we, mem_be, bus_err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_inputs();

        run_access(0, 1, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        check("lw_result", ReadDataM, 32'hDEADBEEF);
        run_access(0, 1, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 0);
        check("lb_result", ReadDataM, 32'hFFFFFF80);
        run_access(0, 1, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 0);
        check("lbu_result", ReadDataM, 32'h00000080);
        run_access(0, 1, 2'd1, 0, 32'h102, 32'h0, 32'h80015A5A, 1);
        check("lh_result", ReadDataM, 32'hFFFF8001);
        run_access(1, 0, 2'd0, 0, 32'h201, 32'h000000AB, 32'h0, 0);
        run_access(1, 1, 2'd1, 0, 32'h202, 32'h00001234, 32'hCAFEF00D, 2);
        check("store_keeps_rdata", ReadDataM, 32'hFFFF8001);
        run_access(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0);
        run_access(0, 1, 2'd1, 0, 32'h101, 32'h0, 32'h0, 0);
        run_access(0, 1, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0);
        run_access(0, 1, 2'd2, 0, 32'h300, 32'h0, 32'h12345678, -1);
        check("timeout_rdata", ReadDataM, 32'd0);
        run_access(0, 1, 2'd2, 0, 32'h304, 32'h0, 32'h0BADF00D, 3);

        // Reset during the second request cycle abandons the load silently
        bus_q.push_back('{32'h400, 4'hF, 1'b0, 32'd0});
        resp_q.push_back('{32'd0, 1'b0, 2, 2});
        exp_rd = 32'd0;
        wait_left = 1000000;
        @(posedge CLK); #1;
        drive(0, 1, 2'd2, 0, 32'h400, 32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        clear_inputs();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_abort_req", {31'd0, mem_req}, 32'd0);
        check("rst_abort_stall", {31'd0, StallM}, 32'd0);
        check("rst_abort_rdata", ReadDataM, 32'd0);
        run_access(1, 0, 2'd2, 0, 32'h500, 32'h87654321, 32'h0, 1);

        for (int n = 0; n < 60; n++) begin
            bit st, ld, zx;
            logic [1:0] sz;
            logic [31:0] a;
            st = 1'($urandom % 2);
            ld = 1'($urandom % 2);
            zx = 1'($urandom % 2);
            sz = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
            a = $urandom;
            if ($urandom % 5 != 0 && sz != 3) a = a & ~((32'd1 << sz) - 1);
            run_access(st, ld, sz, zx, a, $urandom, $urandom, int'($urandom % 4));
        end

        repeat (4) @(negedge CLK);
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("bus_err_pulses", berr_pulses, exp_berr_pulses);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It is the consuming end of the execute-to-memory pipeline register interface.
- Takes the M-stage control and data signals, drives a single-outstanding valid/ready data-memory bus, and returns aligned, extended load data.
- Stalls the pipeline while a bus access is in flight.
- Sits between the E→M register and the M→W register; ReadDataM feeds the M→W register.

Parameters:
- TIMEOUT, 16, max cycles in REQ without mem_ready before the access aborts with bus_err (range 2..255).
- ADDR_W, 32, width of ALUResultM and mem_addr.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- RegWriteM  in  1  M-stage register write enable (passed through only, for hazard visibility)
- ResultSrcM  in  2  2'b01 marks a load
- MemWriteM  in  1  store request
- ALUResultM  in  ADDR_W  effective byte address
- WriteDataM  in  32  store data, LSB-justified
- MemSizeM  in  2  0=byte, 1=half, 2=word, 3=illegal
- MemSignM  in  1  1=zero-extend load, 0=sign-extend
- ReadDataM  out  32  extended load result, valid in DONE
- StallM  out  1  hold F/D/E/M pipeline registers
- misalign_err  out  1  combinational: access is misaligned or has an illegal size
- bus_err  out  1  one-cycle pulse on timeout
- mem_req  out  1  bus request, registered
- mem_we  out  1  write strobe, registered
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}), registered
- mem_be  out  4  byte enables, registered
- mem_wdata  out  32  lane-replicated store data, registered
- mem_ready  in  1  bus accepts/completes the beat; write done, or rdata valid the same cycle
- mem_rdata  in  32  read data, sampled when mem_req & mem_ready

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM, bus_err, timeout counter all 0.
  - StallM forced 0 while RST=1.
- access = (MemWriteM | ResultSrcM==2'b01) & ~misalign_err.
- Store has priority if both MemWriteM and a load are flagged: mem_we=1.
- misalign_err:
  - Asserted for size 1 with addr[0]=1, size 2 with addr[1:0]≠0, or size 3, when MemWriteM or load is flagged.
  - No bus request is issued; StallM=0; ReadDataM unchanged.
- FSM IDLE:
  - On access, StallM=1 (combinational).
  - Register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata.
  - Go to REQ; clear the timeout counter.
- FSM REQ:
  - StallM=1; bus outputs held stable.
  - On mem_ready: drop mem_req at the next edge; for a load, capture the extracted rdata into ReadDataM; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready: drop mem_req, set ReadDataM=0, pulse bus_err for 1 cycle (during DONE), go to DONE.
- FSM DONE:
  - StallM=0, so the M→W register captures at the end of this cycle.
  - Go to IDLE unconditionally; bus_err clears.
- Latency: min 3 cycles per access (IDLE, REQ with ready, DONE). Each extra wait cycle adds 1. Back-to-back accesses restart at IDLE.
- Non-memory instructions in IDLE: StallM=0, no bus activity, ReadDataM holds.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0] (addr[1:0] ∈ {0,2}).
  - word: 4'b1111.
- Write data: byte → {4{wd[7:0]}}; half → {2{wd[15:0]}}; word → wd.
- Load extraction:
  - sh = mem_rdata >> (8*addr[1:0]).
  - byte: sh[7:0]; half: sh[15:0]; word: mem_rdata.
  - Extend to 32 bits per MemSignM (0 = sign-extend, 1 = zero-extend).
  - Uses the address latched at IDLE, not the live ALUResultM.
- Store with mem_ready: ReadDataM unchanged.
- mem_ready while not in REQ is ignored.
- RST asserted in REQ: at the next edge state=IDLE and mem_req=0. The access is abandoned, with no bus_err and no ReadDataM update.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, mem_ready in first REQ cycle → mem_addr=0x100, mem_be=4'hF, StallM high 2 cycles; DONE shows ReadDataM=0xDEADBEEF.
- LB addr=0x103, MemSignM=0, rdata=0x80112233 → ReadDataM=0xFFFFFF80. The same access as LBU (MemSignM=1) → 0x00000080. LH addr=0x102, MemSignM=0, rdata=0x8001xxxx → 0xFFFF8001.
- SB addr=0x201, WriteDataM=0x000000AB → mem_we=1, mem_be=4'b0010, mem_wdata=0xABABABAB, mem_addr=0x200. SH addr=0x202, WriteDataM=0x1234 → mem_be=4'b1100, mem_wdata=0x12341234.
- SW addr=0x102, and LH addr=0x101 → misalign_err=1, mem_req stays 0, StallM=0. MemSizeM=3 with a load flagged → misalign_err=1.
- Load with mem_ready held 0, TIMEOUT=16 → mem_req high for 16 cycles, then bus_err pulses 1 cycle, ReadDataM=0, state returns to IDLE. Repeat with ready on wait cycle 3 → StallM high 5 cycles.
- RST=1 in the second REQ cycle → next edge mem_req=0, StallM=0, ReadDataM=0. A following SW completes normally.
